// File: rtl/sram_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// sram_mem_responder_pkg
// Shared definitions for the MEM-stage SRAM responder: bus widths, the
// responder state encoding and a helper that sizes the phase counter.
// No ports (package).
// ---------------------------------------------------------------------------
package sram_mem_responder_pkg;

    localparam int ADDRESS_LEN   = 32;
    localparam int REGISTER_LEN  = 32;
    localparam int SRAM_DATA_LEN = 16;

    typedef enum logic [2:0] {
        SRAM_IDLE  = 3'd0,
        SRAM_RD_LO = 3'd1,
        SRAM_RD_HI = 3'd2,
        SRAM_WR_LO = 3'd3,
        SRAM_WR_HI = 3'd4,
        SRAM_DONE  = 3'd5
    } sram_state_t;

    // The counter only ever holds ACCESS_CYCLES-1 down to 0, so
    // clog2(ACCESS_CYCLES) bits suffice; keep at least one bit.
    function automatic int count_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sram_mem_responder_phase_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
// Loadable down-counter that times one halfword phase on the SRAM bus.
// It counts down to zero and then rests there until reloaded.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low (count -> 0)
//   load       in   reload the counter with load_value this cycle
//   load_value in   WIDTH  value loaded on phase entry
//   count      out  WIDTH  current count
//   is_zero    out  high when count is zero (last cycle of a phase)
// ---------------------------------------------------------------------------
module phase_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/sram_mem_responder.sv
// ---------------------------------------------------------------------------
// sram_mem_responder
// Responder end of the MEM-stage data-memory interface. A 32-bit word read
// or write is carried out as two halfword accesses (low half, then high
// half) on an external 16-bit asynchronous SRAM. Each halfword phase is held
// on the bus for ACCESS_CYCLES clocks. ready stays low while an access is in
// flight and pulses high for one cycle when it completes.
//
// Optional feature: define SRAM_ADDR_CHECK_EN to add the addr_err output and
// reject addresses that are below BASE_ADDR, misaligned or beyond the SRAM.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-low
//   rd_en       in   word read request
//   wr_en       in   word write request (wins over rd_en)
//   address     in   32  byte address, word aligned
//   write_data  in   32  store data
//   read_data   out  32  load data, held until the next read completes
//   ready       out  request complete / responder idle
//   sram_addr   out  SRAM_ADDR_LEN  SRAM halfword address
//   sram_dq_out out  16  write data towards the SRAM
//   sram_dq_in  in   16  read data from the SRAM
//   sram_dq_oe  out  data bus drive enable for the pad tristate
//   sram_we_n   out  SRAM write strobe, active-low
//   addr_err    out  (SRAM_ADDR_CHECK_EN only) rejected address, DONE cycle
// ---------------------------------------------------------------------------
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter int BASE_ADDR     = 1024,
    parameter int SRAM_ADDR_LEN = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [ADDRESS_LEN-1:0]   address,
    input  logic [REGISTER_LEN-1:0]  write_data,
    output logic [REGISTER_LEN-1:0]  read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_dq_oe,
`ifdef SRAM_ADDR_CHECK_EN
    output logic                     addr_err,
`endif
    output logic                     sram_we_n
);

    localparam int                     CNT_W        = count_width(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0]       RELOAD       = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [ADDRESS_LEN-1:0] BASE         = ADDRESS_LEN'(BASE_ADDR);
    localparam int                     WORD_IDX_LEN = SRAM_ADDR_LEN - 1;

    sram_state_t                  state;
    logic [WORD_IDX_LEN-1:0]      word_idx;
    logic [SRAM_DATA_LEN-1:0]     wdata_hi;
    logic [ADDRESS_LEN-1:0]       offset;
    logic [WORD_IDX_LEN-1:0]      req_word;
    logic                         request;
    logic                         addr_bad;
    logic                         cnt_load;
    logic                         cnt_zero;
    logic [CNT_W-1:0]             cnt_value;
    logic                         unused_offset_bits;

    // Byte offset into the SRAM window; wraps modulo 2^32 and the word index
    // keeps only the bits that address the SRAM.
    assign offset   = address - BASE;
    assign req_word = offset[SRAM_ADDR_LEN:2];
    assign request  = rd_en | wr_en;

    assign unused_offset_bits = &{1'b0, offset[ADDRESS_LEN-1:SRAM_ADDR_LEN+1],
                                  offset[1:0], cnt_value};

`ifdef SRAM_ADDR_CHECK_EN
    // Offsets at or beyond 2^(SRAM_ADDR_LEN+1) bytes correspond to word
    // indices that do not fit in the SRAM.
    assign addr_bad = (address < BASE) ||
                      (address[1:0] != 2'b00) ||
                      ((offset >> (SRAM_ADDR_LEN + 1)) != '0);
`else
    assign addr_bad = 1'b0;
`endif

    // Idle reports ready unless a request is waiting; DONE is the one-cycle
    // completion pulse.
    assign ready = (state == SRAM_DONE) || ((state == SRAM_IDLE) && !request);

    // The phase timer is reloaded whenever a LO or HI phase is entered:
    // from IDLE on a request, and from a LO phase on its last cycle.
    always_comb begin
        cnt_load = 1'b0;
        case (state)
            SRAM_IDLE:              cnt_load = request;
            SRAM_RD_LO, SRAM_WR_LO: cnt_load = cnt_zero;
            default:                cnt_load = 1'b0;
        endcase
    end

    phase_counter #(
        .WIDTH(CNT_W)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (RELOAD),
        .count      (cnt_value),
        .is_zero    (cnt_zero)
    );

    // Main sequencer. Bus outputs are registered and set up on the edge that
    // enters each phase, so they are stable for the whole phase. Read data is
    // captured on the last cycle of each read phase, when the SRAM has had
    // the full ACCESS_CYCLES to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SRAM_IDLE;
            word_idx    <= '0;
            wdata_hi    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
            addr_err    <= 1'b0;
`endif
        end else begin
            case (state)
                SRAM_IDLE: begin
                    if (request) begin
                        if (addr_bad) begin
                            state <= SRAM_DONE;
`ifdef SRAM_ADDR_CHECK_EN
                            addr_err <= 1'b1;
`endif
                        end else begin
                            word_idx  <= req_word;
                            wdata_hi  <= write_data[REGISTER_LEN-1:SRAM_DATA_LEN];
                            sram_addr <= {req_word, 1'b0};
                            if (wr_en) begin
                                state       <= SRAM_WR_LO;
                                sram_dq_out <= write_data[SRAM_DATA_LEN-1:0];
                                sram_dq_oe  <= 1'b1;
                                sram_we_n   <= 1'b0;
                            end else begin
                                state <= SRAM_RD_LO;
                            end
                        end
                    end
                end
                SRAM_RD_LO: begin
                    if (cnt_zero) begin
                        read_data[SRAM_DATA_LEN-1:0] <= sram_dq_in;
                        sram_addr <= {word_idx, 1'b1};
                        state     <= SRAM_RD_HI;
                    end
                end
                SRAM_RD_HI: begin
                    if (cnt_zero) begin
                        read_data[REGISTER_LEN-1:SRAM_DATA_LEN] <= sram_dq_in;
                        state <= SRAM_DONE;
                    end
                end
                SRAM_WR_LO: begin
                    if (cnt_zero) begin
                        sram_addr   <= {word_idx, 1'b1};
                        sram_dq_out <= wdata_hi;
                        state       <= SRAM_WR_HI;
                    end
                end
                SRAM_WR_HI: begin
                    if (cnt_zero) begin
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        state      <= SRAM_DONE;
                    end
                end
                SRAM_DONE: begin
                    state <= SRAM_IDLE;
`ifdef SRAM_ADDR_CHECK_EN
                    addr_err <= 1'b0;
`endif
                end
                default: begin
                    state <= SRAM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_responder
// Directed testbench for sram_mem_responder with a behavioural 16-bit SRAM.
// Expected read_data values are queued when a request is issued and popped
// when the responder signals completion.
// ---------------------------------------------------------------------------
module tb_sram_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int          check_count = 0;
    int          error_count = 0;
    logic [31:0] expect_q[$];
    logic [15:0] sram_mem [0:63];
    logic [17:0] log_addr [0:31];
    logic [15:0] log_dq   [0:31];
    logic        log_we   [0:31];
    logic        log_oe   [0:31];
    int          done_cycle;

    sram_mem_responder #(
        .BASE_ADDR     (1024),
        .SRAM_ADDR_LEN (18),
        .ACCESS_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
`ifdef SRAM_ADDR_CHECK_EN
        .addr_err    (addr_err),
`endif
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: preloaded while reset is held, written on any clock
    // where the strobe is low and the bus is driven.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= 16'h0000;
            sram_mem[0] <= 16'hBEEF;
            sram_mem[1] <= 16'hDEAD;
        end else if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request, log the bus every cycle until ready, then release
    // the request and compare completion latency and read_data.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input int exp_cycles);
        @(posedge clk);
        #1;
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        #1;
        checkOutput("ready_busy", 32'(ready), 32'd0);
        done_cycle = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            log_addr[c] = sram_addr;
            log_dq[c]   = sram_dq_out;
            log_we[c]   = sram_we_n;
            log_oe[c]   = sram_dq_oe;
            if (ready) begin
                done_cycle = c;
                break;
            end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        checkOutput("done_cycle", 32'(done_cycle), 32'(exp_cycles));
        if (expect_q.size() > 0) checkOutput("read_data", read_data, expect_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        // Reset held with a pending read: outputs at reset values.
        rst        = 1'b0;
        rd_en      = 1'b1;
        wr_en      = 1'b0;
        address    = 32'd1024;
        write_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_read_data", read_data, 32'd0);
        checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_dq_out", 32'(sram_dq_out), 32'd0);
        checkOutput("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
`ifdef SRAM_ADDR_CHECK_EN
        checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
`endif
        rd_en = 1'b0;
        rst   = 1'b1;
        #1;
        checkOutput("idle_ready", 32'(ready), 32'd1);

        // Read at 1024 -> halfwords 0 then 1.
        expect_q.push_back(32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0, 5);
        checkOutput("rd0_addr_c1", 32'(log_addr[1]), 32'd0);
        checkOutput("rd0_addr_c2", 32'(log_addr[2]), 32'd0);
        checkOutput("rd0_addr_c3", 32'(log_addr[3]), 32'd1);
        checkOutput("rd0_addr_c4", 32'(log_addr[4]), 32'd1);
        checkOutput("rd0_oe_c1", 32'(log_oe[1]), 32'd0);
        checkOutput("rd0_we_c3", 32'(log_we[3]), 32'd1);
`ifdef SRAM_ADDR_CHECK_EN
        checkOutput("rd0_addr_err", 32'(addr_err), 32'd0);
`endif

        // Write 0x12345678 at 1028 -> halfwords 2 and 3; read_data untouched.
        expect_q.push_back(32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'h12345678, 5);
        checkOutput("wr_addr_c1", 32'(log_addr[1]), 32'd2);
        checkOutput("wr_dq_c1", 32'(log_dq[1]), 32'h5678);
        checkOutput("wr_we_c1", 32'(log_we[1]), 32'd0);
        checkOutput("wr_we_c2", 32'(log_we[2]), 32'd0);
        checkOutput("wr_oe_c2", 32'(log_oe[2]), 32'd1);
        checkOutput("wr_addr_c3", 32'(log_addr[3]), 32'd3);
        checkOutput("wr_dq_c3", 32'(log_dq[3]), 32'h1234);
        checkOutput("wr_we_c4", 32'(log_we[4]), 32'd0);
        checkOutput("wr_we_done", 32'(log_we[5]), 32'd1);
        checkOutput("wr_oe_done", 32'(log_oe[5]), 32'd0);

        // Read back the written word.
        expect_q.push_back(32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0, 5);

        // Simultaneous read and write at 1032: write wins.
        expect_q.push_back(32'h12345678);
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 5);
        checkOutput("both_we_c1", 32'(log_we[1]), 32'd0);
        checkOutput("both_addr_c3", 32'(log_addr[3]), 32'd5);
        expect_q.push_back(32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, 5);

        // Reset during the high write phase aborts immediately.
        @(posedge clk);
        #1;
        wr_en      = 1'b1;
        address    = 32'd1036;
        write_data = 32'hA5A55A5A;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midwr_we_hi", 32'(sram_we_n), 32'd0);
        checkOutput("midwr_addr_hi", 32'(sram_addr), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("abort_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("abort_ready", 32'(ready), 32'd0);
        checkOutput("abort_read_data", read_data, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_ready_hold", 32'(ready), 32'd0);
        wr_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("post_abort_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("post_abort_idle_we", 32'(sram_we_n), 32'd1);
        checkOutput("post_abort_idle_rdy", 32'(ready), 32'd1);

        // Normal service resumes after the aborted access.
        expect_q.push_back(32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0, 5);

`ifdef SRAM_ADDR_CHECK_EN
        // Below the base address: straight to DONE, no SRAM activity.
        expect_q.push_back(32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd1000, 32'd0, 1);
        checkOutput("low_addr_err", 32'(addr_err), 32'd1);
        checkOutput("low_we_c1", 32'(log_we[1]), 32'd1);
        checkOutput("low_addr_held", 32'(log_addr[1]), 32'd1);
        // Misaligned address behaves the same way.
        expect_q.push_back(32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd1026, 32'd0, 1);
        checkOutput("mis_addr_err", 32'(addr_err), 32'd1);
        checkOutput("mis_we_c1", 32'(log_we[1]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("err_cleared", 32'(addr_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
